// File: rtl/pid_mixer_pkg.sv
// pid_mixer_pkg: shared constants for the quad-X mixer (sign table, throttle cutoff, width helper)
package pid_mixer_pkg;

    // Bit positions of the operand columns inside a sign-select word
    localparam int COL_T = 3;
    localparam int COL_P = 2;
    localparam int COL_R = 1;
    localparam int COL_Y = 0;

    // One bit per column: 1 = subtract that operand, 0 = add it
    typedef logic [3:0] sign_sel_t;

    // Index 0 = motor 1 ... index 3 = motor 4
    //   m1 = T + P + R - Y
    //   m2 = T + P - R + Y
    //   m3 = T - P - R - Y
    //   m4 = T - P + R + Y
    localparam sign_sel_t [3:0] MOTOR_NEG = {4'b0100, 4'b0111, 4'b0010, 4'b0001};

    // Throttle at or below this value (signed, input LSBs) forces motors off when the cutoff is built in
    localparam int MIXER_THROTTLE_CUTOFF = 64;

    // Width that holds a four-operand signed sum without overflow
    function automatic int ext_width(input int rate_w, input int motor_w);
        return ((rate_w > motor_w) ? rate_w : motor_w) + 2;
    endfunction

endpackage

// File: rtl/pid_mixer_sat.sv
// mixer_sat: signed four-operand add/subtract, clamped to [0, 2^(MW-1)-1]
module mixer_sat
    import pid_mixer_pkg::*;
#(
    parameter int W  = 38,
    parameter int MW = 36
) (
    input  logic signed [W-1:0]  t,
    input  logic signed [W-1:0]  p,
    input  logic signed [W-1:0]  r,
    input  logic signed [W-1:0]  y,
    input  sign_sel_t            neg,
    output logic        [MW-1:0] sat
);

    localparam logic signed [W-1:0] MAX = {{(W-MW+1){1'b0}}, {(MW-1){1'b1}}};

    logic signed [W-1:0] sum;

    assign sum = (neg[COL_T] ? -t : t) + (neg[COL_P] ? -p : p)
               + (neg[COL_R] ? -r : r) + (neg[COL_Y] ? -y : y);

    // Negative sums floor at zero; oversize sums clamp to the largest positive motor rate
    always_comb begin
        sat = sum[W-1] ? {MW{1'b0}} : (sum > MAX) ? MAX[MW-1:0] : sum[MW-1:0];
    end

endmodule

// File: rtl/pid_mixer.sv
// pid_mixer: quad-X motor mixer, 2-cycle registered pipeline with saturation.
// Optional throttle cutoff built when PID_MIXER_THROTTLE_CUTOFF_EN is defined.
module pid_mixer
    import pid_mixer_pkg::*;
#(
    parameter int RATE_BIT_WIDTH       = 36,
    parameter int MOTOR_RATE_BIT_WIDTH = 36
) (
    input  logic                                   sys_clk,
    input  logic                                   rst,
    input  logic signed [RATE_BIT_WIDTH-1:0]       throttle_rate,
    input  logic signed [RATE_BIT_WIDTH-1:0]       yaw_rate,
    input  logic signed [RATE_BIT_WIDTH-1:0]       roll_rate,
    input  logic signed [RATE_BIT_WIDTH-1:0]       pitch_rate,
    output logic        [MOTOR_RATE_BIT_WIDTH-1:0] motor_1_rate,
    output logic        [MOTOR_RATE_BIT_WIDTH-1:0] motor_2_rate,
    output logic        [MOTOR_RATE_BIT_WIDTH-1:0] motor_3_rate,
    output logic        [MOTOR_RATE_BIT_WIDTH-1:0] motor_4_rate
);

    localparam int RW = RATE_BIT_WIDTH;
    localparam int MW = MOTOR_RATE_BIT_WIDTH;
    localparam int W  = ext_width(RW, MW);

    logic signed [RW-1:0]        t_q, y_q, r_q, p_q;
    logic signed [W-1:0]         t_x, y_x, r_x, p_x;
    logic        [3:0][MW-1:0]   mix, m_q;
    logic                        cut;

    // Stage 1: capture every input each cycle
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            t_q <= '0;
            y_q <= '0;
            r_q <= '0;
            p_q <= '0;
        end else begin
            t_q <= throttle_rate;
            y_q <= yaw_rate;
            r_q <= roll_rate;
            p_q <= pitch_rate;
        end
    end

    assign t_x = {{(W-RW){t_q[RW-1]}}, t_q};
    assign y_x = {{(W-RW){y_q[RW-1]}}, y_q};
    assign r_x = {{(W-RW){r_q[RW-1]}}, r_q};
    assign p_x = {{(W-RW){p_q[RW-1]}}, p_q};

    for (genvar i = 0; i < 4; i++) begin : g_mot
        mixer_sat #(.W(W), .MW(MW)) u_sat (
            .t   (t_x),
            .p   (p_x),
            .r   (r_x),
            .y   (y_x),
            .neg (MOTOR_NEG[i]),
            .sat (mix[i])
        );
    end

`ifdef PID_MIXER_THROTTLE_CUTOFF_EN
    localparam logic signed [W-1:0] CUT = W'(MIXER_THROTTLE_CUTOFF);
    assign cut = (t_x <= CUT);
`else
    assign cut = 1'b0;
`endif

    // Stage 2: register the saturated mix, or zeros when throttle is cut off
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) m_q <= '0;
        else     m_q <= cut ? '0 : mix;
    end

    assign motor_1_rate = m_q[0];
    assign motor_2_rate = m_q[1];
    assign motor_3_rate = m_q[2];
    assign motor_4_rate = m_q[3];

endmodule

// File: tb/tb_pid_mixer.sv
// tb_pid_mixer: scoreboard bench for pid_mixer using directed vectors
module tb_pid_mixer;

    localparam logic signed [35:0] MAXV = 36'h7_FFFF_FFFF;
    localparam logic signed [35:0] MINV = 36'h8_0000_0000;

    logic               sys_clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [35:0] throttle_rate = 36'sd1000;
    logic signed [35:0] yaw_rate = '0;
    logic signed [35:0] roll_rate = '0;
    logic signed [35:0] pitch_rate = '0;
    logic        [35:0] motor_1_rate, motor_2_rate, motor_3_rate, motor_4_rate;

    typedef struct {
        int                 due;
        logic [3:0][35:0]   m;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   tests = 0;
    int   failed = 0;

    pid_mixer dut (
        .sys_clk       (sys_clk),
        .rst           (rst),
        .throttle_rate (throttle_rate),
        .yaw_rate      (yaw_rate),
        .roll_rate     (roll_rate),
        .pitch_rate    (pitch_rate),
        .motor_1_rate  (motor_1_rate),
        .motor_2_rate  (motor_2_rate),
        .motor_3_rate  (motor_3_rate),
        .motor_4_rate  (motor_4_rate)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [35:0] act, input logic [35:0] req);
        tests++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push(input int due, input logic [35:0] e1, e2, e3, e4);
        exp_t e;
        e.due = due;
        e.m   = {e4, e3, e2, e1};
        sbq.push_back(e);
    endtask

    // Drive one vector right after a rising edge; its result is due two edges later
    task automatic apply(input logic signed [35:0] t, y, r, p, input logic [35:0] e1, e2, e3, e4);
        @(posedge sys_clk);
        #1;
        throttle_rate = t;
        yaw_rate      = y;
        roll_rate     = r;
        pitch_rate    = p;
        push(cyc + 2, e1, e2, e3, e4);
    endtask

    // Release reset after an edge: first edge still shows zeros, second shows the held inputs mixed
    task automatic release_rst(input logic [35:0] e1, e2, e3, e4);
        @(posedge sys_clk);
        #1;
        rst = 1'b0;
        push(cyc + 1, 36'd0, 36'd0, 36'd0, 36'd0);
        push(cyc + 2, e1, e2, e3, e4);
    endtask

    // Monitor: compare the DUT against the head of the scoreboard when its slot comes due
    always @(negedge sys_clk) begin
        if (!rst) begin
            while (sbq.size() > 0 && sbq[0].due < cyc) begin
                chk("missed_slot", 36'd0, 36'd1);
                void'(sbq.pop_front());
            end
            if (sbq.size() > 0 && sbq[0].due == cyc) begin
                exp_t e;
                e = sbq.pop_front();
                chk("m1", motor_1_rate, e.m[0]);
                chk("m2", motor_2_rate, e.m[1]);
                chk("m3", motor_3_rate, e.m[2]);
                chk("m4", motor_4_rate, e.m[3]);
            end
        end
    end

    initial begin
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst_hold_m1", motor_1_rate, 36'd0);
        chk("rst_hold_m2", motor_2_rate, 36'd0);
        chk("rst_hold_m3", motor_3_rate, 36'd0);
        chk("rst_hold_m4", motor_4_rate, 36'd0);
        release_rst(36'd1000, 36'd1000, 36'd1000, 36'd1000);
        apply(36'sd1000, 36'sd0, 36'sd100, 36'sd0, 36'd1100, 36'd900, 36'd900, 36'd1100);
        apply(36'sd1000, 36'sd50, 36'sd0, -36'sd20, 36'd930, 36'd1030, 36'd970, 36'd1070);
        apply(36'sd0, 36'sd0, 36'sd0, -36'sd10, 36'd0, 36'd0, 36'd10, 36'd10);
        apply(MAXV, 36'sd0, 36'sd0, 36'sd1, MAXV, MAXV, MAXV - 36'd1, MAXV - 36'd1);
        apply(MINV, 36'sd0, 36'sd0, 36'sd0, 36'd0, 36'd0, 36'd0, 36'd0);
        apply(MAXV, 36'sd0, MAXV, 36'sd0, MAXV, 36'd0, 36'd0, MAXV);
`ifdef PID_MIXER_THROTTLE_CUTOFF_EN
        apply(36'sd64, 36'sd0, 36'sd500, 36'sd0, 36'd0, 36'd0, 36'd0, 36'd0);
`else
        apply(36'sd64, 36'sd0, 36'sd500, 36'sd0, 36'd564, 36'd0, 36'd0, 36'd564);
`endif
        apply(36'sd65, 36'sd0, 36'sd0, 36'sd0, 36'd65, 36'd65, 36'd65, 36'd65);
        apply(36'sd1000, 36'sd0, 36'sd100, 36'sd0, 36'd1100, 36'd900, 36'd900, 36'd1100);
        apply(36'sd1000, 36'sd50, 36'sd0, -36'sd20, 36'd930, 36'd1030, 36'd970, 36'd1070);
        @(posedge sys_clk);
        #3;
        rst = 1'b1;
        sbq.delete();
        #1;
        chk("async_rst_m1", motor_1_rate, 36'd0);
        chk("async_rst_m2", motor_2_rate, 36'd0);
        chk("async_rst_m3", motor_3_rate, 36'd0);
        chk("async_rst_m4", motor_4_rate, 36'd0);
        release_rst(36'd930, 36'd1030, 36'd970, 36'd1070);
        apply(36'sd1000, 36'sd0, 36'sd100, 36'sd0, 36'd1100, 36'd900, 36'd900, 36'd1100);
        for (int i = 0; i < 20 && sbq.size() > 0; i++) @(posedge sys_clk);
        @(negedge sys_clk);
        #1;
        chk("drain_pending", 36'(sbq.size()), 36'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pid_mixer.md
Name: pid_mixer

Overview:
- Quad-X motor mixer between the PID rate controllers and the per-motor ESC/PWM generators.
- Combines throttle, yaw, roll and pitch rate commands into four motor rate commands.
- Uses signed fixed-point arithmetic with saturation and a fixed 2-cycle registered pipeline on sys_clk.

Parameters:
- RATE_BIT_WIDTH, 36, width of each 2's complement input rate (fixed point, binary point irrelevant to mixer).
- MOTOR_RATE_BIT_WIDTH, 36, width of each 2's complement motor rate output (same binary point as inputs).

Ports:
- sys_clk  input  1  system clock, all logic rising-edge.
- rst  input  1  reset; one clock, asynchronous, active-high; clears all state immediately.
- throttle_rate  input  RATE_BIT_WIDTH  collective thrust command, signed.
- yaw_rate  input  RATE_BIT_WIDTH  yaw correction, signed; positive = clockwise viewed from above.
- roll_rate  input  RATE_BIT_WIDTH  roll correction, signed; positive = right side down.
- pitch_rate  input  RATE_BIT_WIDTH  pitch correction, signed; positive = nose up.
- motor_1_rate  output  MOTOR_RATE_BIT_WIDTH  front-left motor (CW prop).
- motor_2_rate  output  MOTOR_RATE_BIT_WIDTH  front-right motor (CCW prop).
- motor_3_rate  output  MOTOR_RATE_BIT_WIDTH  rear-right motor (CW prop).
- motor_4_rate  output  MOTOR_RATE_BIT_WIDTH  rear-left motor (CCW prop).

Behaviour:
- Stage 1: register all four inputs every cycle; no handshake, free-running.
- Stage 2: compute and register the four mixed outputs. Latency is 2 cycles from input to output; throughput is 1 per cycle.
- Mixing equations:
  - m1 = T + P + R − Y
  - m2 = T + P − R + Y
  - m3 = T − P − R − Y
  - m4 = T − P + R + Y
- Arithmetic width:
  - Sign-extend all operands to W = max(RATE_BIT_WIDTH, MOTOR_RATE_BIT_WIDTH) + 2 bits before summing. No intermediate overflow is possible.
- Saturation (applied to each sum):
  - sum < 0 → output 0; motors never commanded negative.
  - sum > 2^(MOTOR_RATE_BIT_WIDTH−1)−1 → output that maximum.
  - otherwise output the sum truncated to MOTOR_RATE_BIT_WIDTH (lossless in range).
  - Outputs are therefore always non-negative 2's complement values.
- Reset:
  - While rst is high, all stage-1 registers and all four outputs are 0.
  - Asserting rst mid-operation clears the pipeline asynchronously.
  - After deassertion, outputs stay 0 until new inputs propagate: first mixed value appears at the 2nd rising edge after release.
- Changing inputs every cycle must produce independently mixed results with no cross-cycle interaction.
- No combinational path from any input to any output.

Optional Feature:
- Macro PID_MIXER_THROTTLE_CUTOFF_EN.
- When defined: if the stage-1 registered throttle_rate ≤ MIXER_THROTTLE_CUTOFF (signed compare), all four outputs are forced to 0 in stage 2, regardless of yaw/roll/pitch. Latency is unchanged.
- When undefined: no cutoff logic; pure mixing and saturation.

Decomposition:
- Package pid_mixer_pkg:
  - per-motor sign constants for the T/P/R/Y columns (the table above);
  - MIXER_THROTTLE_CUTOFF (default 64, signed, in input LSBs);
  - helper function for the extended width W.
- One sub-module mixer_sat, instantiated four times:
  - takes the four sign-extended operands plus sign selects;
  - returns the saturated MOTOR_RATE_BIT_WIDTH result combinationally;
  - pid_mixer owns both pipeline register stages.

Test Plan:
1. Reset: hold rst=1 with T=1000 → all motors 0. Release rst → all motors 1000 on the 2nd rising edge after release.
2. Roll: T=1000, R=100, Y=P=0 → m1=1100, m2=900, m3=900, m4=1100 after 2 cycles.
3. Yaw and pitch: T=1000, Y=50, P=−20, R=0 → m1=930, m2=1030, m3=970, m4=1070.
4. Low saturation: T=0, P=−10, Y=R=0 → m1=0, m2=0, m3=10, m4=10.
5. High saturation: T=34359738367, P=1 → m1=m2=34359738367; m3=m4=34359738366. T=−34359738368, all else 0 → all outputs 0.
6. Streaming and mid-run reset: change inputs every cycle → each result appears exactly 2 cycles later. Assert rst mid-stream → outputs go to 0 immediately without waiting for a clock edge. With PID_MIXER_THROTTLE_CUTOFF_EN: T=64, R=500 → all outputs 0; T=65, R=0 → all outputs 65.
